// File: rtl/surf_command_receiver_if.sv
// Signal bundle between the CMD line pin and the SURF command receiver.
// Member names follow the receiver's view (CMD_i in, everything else out).
interface surf_command_receiver_if;
  logic        CMD_i;
  logic [31:0] event_id_o;
  logic [1:0]  buffer_o;
  logic        valid_o;
  logic        err_o;
  logic        busy_o;
  logic [7:0]  err_count_o;

  modport slave (
    input  CMD_i,
    output event_id_o, buffer_o, valid_o, err_o, busy_o, err_count_o
  );

  modport master (
    output CMD_i,
    input  event_id_o, buffer_o, valid_o, err_o, busy_o, err_count_o
  );
endinterface

// File: rtl/surf_command_receiver.sv
// SURF-side decoder for the TURF->SURF serial CMD line: recovers a 2-bit buffer
// number and a 32-bit event ID, flags framing errors and false starts.
module surf_command_receiver #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  surf_command_receiver_if.slave  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_LOW} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   primed_q;
  logic                   s_prev_q;
  logic                   s;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bitidx_q, bitidx_d;
  logic [33:0]   shreg_q, shreg_d;
  logic [31:0]   event_id_q, event_id_d;
  logic [1:0]    buffer_q, buffer_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          bump;

  assign s = sync_q[SYNC_STAGES-1];

  // The synchroniser flops reset low, so s rises by itself when the line is
  // already high at reset release; primed_q masks that artificial edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q   <= '0;
      primed_q <= '0;
      s_prev_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.CMD_i};
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
      s_prev_q <= s;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bitidx_d    = bitidx_q;
    shreg_d     = shreg_q;
    event_id_d  = event_id_q;
    buffer_d    = buffer_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    bump        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (primed_q[SYNC_STAGES] && s && !s_prev_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (s) begin
            state_d  = DATA;
            bitidx_d = '0;
          end else begin
            state_d = IDLE;
            bump    = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          shreg_d  = {s, shreg_q[33:1]};
          bitidx_d = bitidx_q + 6'd1;
          if (bitidx_q == 6'd33) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!s) begin
            state_d    = IDLE;
            valid_d    = 1'b1;
            buffer_d   = shreg_q[1:0];
            event_id_d = shreg_q[33:2];
          end else begin
            state_d = WAIT_LOW;
            err_d   = 1'b1;
            bump    = 1'b1;
          end
        end
      end
      WAIT_LOW: begin
        cnt_d = '0;
        if (!s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (bump && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shreg_q     <= '0;
      event_id_q  <= '0;
      buffer_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shreg_q     <= shreg_d;
      event_id_q  <= event_id_d;
      buffer_q    <= buffer_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.event_id_o  = event_id_q;
  assign bus.buffer_o    = buffer_q;
  assign bus.valid_o     = valid_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.err_count_o = err_count_q;
endmodule

// File: tb/tb_surf_command_receiver.sv
// Directed bench for surf_command_receiver: frames are driven bit by bit and a
// negedge monitor pops expected {event_id, buffer} values on every valid_o.
module tb_surf_command_receiver;
  localparam int CPB  = 8;
  localparam int SYNC = 2;
  // Cycles from driving the start bit on CMD_i to valid_o being visible.
  localparam int LAT  = SYNC + CPB / 2 + 35 * CPB + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  surf_command_receiver_if bus();

  surf_command_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;
  int unsigned t_start = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned last_err_cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [33:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [33:0] e;
    if (bus.valid_o || bus.err_o) begin
      n_checks++;
      assert (!(bus.valid_o && bus.err_o)) else begin
        n_errors++;
        $error("FAIL strobe_overlap got valid=%0b err=%0b want not both", bus.valid_o, bus.err_o);
      end
    end
    if (bus.valid_o) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL unexpected_valid got id=%h buf=%0d want no strobe", bus.event_id_o, bus.buffer_o);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        assert ({bus.event_id_o, bus.buffer_o} === e) else begin
          n_errors++;
          $error("FAIL frame_data got id=%h buf=%0d want id=%h buf=%0d",
                 bus.event_id_o, bus.buffer_o, e[33:2], e[1:0]);
        end
      end
    end
    if (bus.err_o) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Drives the first nbits of a frame starting at a negedge; full good frames
  // are pushed to the scoreboard.
  task automatic send(input logic [1:0] b, input logic [31:0] id, input logic stop, input int nbits);
    logic [35:0] f;
    f = {stop, id, b, 1'b1};
    if (nbits == 36 && !stop) exp_q.push_back({id, b});
    t_start = cyc;
    for (int i = 0; i < nbits; i++) begin
      bus.CMD_i = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic glitch();
    bus.CMD_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.CMD_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    int unsigned c1;

    bus.CMD_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_event_id", bus.event_id_o, 0);
    chk("rst_buffer", bus.buffer_o, 0);
    chk("rst_err_count", bus.err_count_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame at default timing
    v0 = valid_cnt;
    send(2'b10, 32'h12345678, 1'b0, 36);
    chk("t1_count", valid_cnt, v0 + 1);
    chk("t1_latency", last_valid_cyc - t_start, LAT);
    chk("t1_event_id", bus.event_id_o, 32'h12345678);
    chk("t1_buffer", bus.buffer_o, 2'b10);
    chk("t1_busy_idle", bus.busy_o, 0);
    repeat (10) @(negedge clk);

    // Back-to-back frames with no idle gap
    v0 = valid_cnt;
    send(2'd1, 32'hDEADBEEF, 1'b0, 36);
    chk("t2_latency", last_valid_cyc - t_start, LAT);
    c1 = last_valid_cyc;
    send(2'd3, 32'h00000001, 1'b0, 36);
    chk("t2_count", valid_cnt, v0 + 2);
    chk("t2_spacing", last_valid_cyc - c1, 36 * CPB);
    repeat (10) @(negedge clk);

    // Two-clock glitch on an idle line is a false start
    v0 = valid_cnt;
    glitch();
    @(negedge clk);
    chk("t3_busy_start", bus.busy_o, 1);
    repeat (3) @(negedge clk);
    chk("t3_busy_mid", bus.busy_o, 1);
    @(negedge clk);
    chk("t3_busy_fall", bus.busy_o, 0);
    chk("t3_err_count", bus.err_count_o, 1);
    chk("t3_no_valid", valid_cnt, v0);
    repeat (10) @(negedge clk);

    // Bad stop bit held high, then released
    v0 = valid_cnt;
    e0 = err_cnt;
    send(2'd1, 32'hCAFEF00D, 1'b1, 36);
    repeat (20) @(negedge clk);
    chk("t4_err_strobe", err_cnt, e0 + 1);
    chk("t4_err_latency", last_err_cyc - t_start, LAT);
    chk("t4_no_valid", valid_cnt, v0);
    chk("t4_event_kept", bus.event_id_o, 32'h00000001);
    chk("t4_buffer_kept", bus.buffer_o, 2'd3);
    chk("t4_err_count", bus.err_count_o, 2);
    chk("t4_busy_high", bus.busy_o, 1);
    bus.CMD_i = 1'b0;
    @(negedge clk);
    chk("t4_busy_wait", bus.busy_o, 1);
    repeat (2) @(negedge clk);
    chk("t4_busy_fall", bus.busy_o, 0);
    repeat (5) @(negedge clk);
    send(2'd0, 32'h0BADC0DE, 1'b0, 36);
    chk("t4_recover", valid_cnt, v0 + 1);
    repeat (10) @(negedge clk);

    // Reset in the middle of data bit 10
    v0 = valid_cnt;
    send(2'd2, 32'hFFFF0000, 1'b0, 13);
    bus.CMD_i = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", bus.busy_o, 0);
    chk("t5_event_id", bus.event_id_o, 0);
    chk("t5_buffer", bus.buffer_o, 0);
    chk("t5_err_count", bus.err_count_o, 0);
    bus.CMD_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_strobe", valid_cnt, v0);
    send(2'd0, 32'hA5A5A5A5, 1'b0, 36);
    chk("t5_next_frame", valid_cnt, v0 + 1);
    chk("t5_latency", last_valid_cyc - t_start, LAT);
    repeat (10) @(negedge clk);

    // Line stuck high across reset, then saturation of the error counter
    v0 = valid_cnt;
    bus.CMD_i = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("t6_stuck_busy", bus.busy_o, 0);
    chk("t6_stuck_no_valid", valid_cnt, v0);
    chk("t6_stuck_err_count", bus.err_count_o, 0);
    bus.CMD_i = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      glitch();
      repeat (8) @(negedge clk);
      if (i == 253) chk("t6_count_254", bus.err_count_o, 254);
      if (i == 254) chk("t6_count_255", bus.err_count_o, 255);
    end
    chk("t6_saturated", bus.err_count_o, 255);
    chk("t6_busy_end", bus.busy_o, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
